// File: rtl/if_fetch_unit_pkg.sv
// rtl/if_fetch_unit_pkg.sv - shared constants, FSM encoding and helpers for the fetch stage
package if_fetch_unit_pkg;

  localparam logic RST_ENABLE    = 1'b0;
  localparam logic STALL_YES     = 1'b1;
  localparam int   INST_ADDR_BUS = 16;
  localparam int   INST_BUS      = 16;

  typedef enum logic [1:0] {
    IF_BOOT  = 2'd0,
    IF_FETCH = 2'd1,
    IF_DROP  = 2'd2
  } if_state_e;

  // Free FIFO slots once this cycle's pop has been taken into account.
  function automatic logic [1:0] fifo_free(input logic [1:0] count, input logic pop);
    return 2'd2 - count + {1'b0, pop};
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// rtl/if_fetch_unit_if.sv - instruction memory and decode handshake bundle
interface if_fetch_unit_if #(
  parameter int PC_W   = 16,
  parameter int INST_W = 16
);
  logic              imem_req_o;
  logic [PC_W-1:0]   imem_addr_o;
  logic              imem_ack_i;
  logic [INST_W-1:0] imem_data_i;
  logic              id_valid_o;
  logic              id_ready_i;
  logic [PC_W-1:0]   id_pc_o;
  logic [INST_W-1:0] id_inst_o;

  modport master (
    output imem_req_o, imem_addr_o, id_valid_o, id_pc_o, id_inst_o,
    input  imem_ack_i, imem_data_i, id_ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, id_valid_o, id_pc_o, id_inst_o,
    output imem_ack_i, imem_data_i, id_ready_i
  );
endinterface

// File: rtl/if_fifo.sv
// rtl/if_fifo.sv - 2-entry {pc, inst} prefetch buffer with push/pop/flush
module if_fifo
  import if_fetch_unit_pkg::*;
#(
  parameter int PC_W   = 16,
  parameter int INST_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [PC_W-1:0]   push_pc,
  input  logic [INST_W-1:0] push_inst,
  input  logic              pop,
  input  logic              flush,
  output logic [PC_W-1:0]   head_pc,
  output logic [INST_W-1:0] head_inst,
  output logic [1:0]        count,
  output logic              empty
);

  logic [PC_W-1:0]   pc_mem   [2];
  logic [INST_W-1:0] inst_mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic              full;
  logic              do_push;
  logic              do_pop;

  assign full      = (count == 2'd2);
  assign empty     = (count == 2'd0);
  assign do_pop    = pop && !empty;
  // A push into a full buffer is legal only when a pop frees the slot this cycle.
  assign do_push   = push && (!full || do_pop);
  assign head_pc   = pc_mem[rd_ptr];
  assign head_inst = inst_mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      for (int i = 0; i < 2; i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        pc_mem[wr_ptr]   <= push_pc;
        inst_mem[wr_ptr] <= push_inst;
        wr_ptr           <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - fetch stage: PC, single-outstanding imem requests, prefetch FIFO; IF_BYPASS_EN enables ack-to-decode bypass
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int              PC_W     = INST_ADDR_BUS,
  parameter int              INST_W   = INST_BUS,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stallreq_cpu,
  input  logic            branch_flag_i,
  input  logic [PC_W-1:0] branch_target_i,
  if_fetch_unit_if.master bus,
  output logic            stallreq_if_o,
  output logic [PC_W-1:0] pc_test
);

  if_state_e         state;
  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   addr_q;
  logic              pending;

  logic              stall;
  logic              issue;
  logic              req;
  logic [PC_W-1:0]   addr;
  logic              ack;
  logic              accept;
  logic              push;
  logic              pop_fifo;

  logic [PC_W-1:0]   head_pc;
  logic [INST_W-1:0] head_inst;
  logic [1:0]        fifo_count;
  logic              fifo_empty;

  assign stall = (stallreq_cpu == STALL_YES);

  always_comb begin
    pop_fifo = !stall && !fifo_empty && bus.id_ready_i;
    issue    = (state == IF_FETCH) && !stall && !branch_flag_i
               && (fifo_free(fifo_count, pop_fifo) != 2'd0);
    // An outstanding request is never withdrawn and keeps its original address.
    req      = pending || issue;
    addr     = pending ? addr_q : pc;
    ack      = req && bus.imem_ack_i;
    accept   = ack && (state == IF_FETCH) && !branch_flag_i;
  end

`ifdef IF_BYPASS_EN
  logic bypass;
  always_comb begin
    bypass         = accept && fifo_empty && !stall;
    push           = accept && !(bypass && bus.id_ready_i);
    bus.id_valid_o = bypass || (!fifo_empty && !stall);
    bus.id_pc_o    = bypass ? addr : head_pc;
    bus.id_inst_o  = bypass ? bus.imem_data_i : head_inst;
  end
`else
  always_comb begin
    push           = accept;
    bus.id_valid_o = !fifo_empty && !stall;
    bus.id_pc_o    = head_pc;
    bus.id_inst_o  = head_inst;
  end
`endif

  assign bus.imem_req_o  = req;
  assign bus.imem_addr_o = addr;
  assign stallreq_if_o   = fifo_empty && bus.id_ready_i && !stall;
  assign pc_test         = pc;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state   <= IF_BOOT;
      pc      <= RESET_PC;
      addr_q  <= RESET_PC;
      pending <= 1'b0;
    end else begin
      pending <= req && !bus.imem_ack_i;
      addr_q  <= addr;
      case (state)
        IF_BOOT:  state <= IF_FETCH;
        IF_FETCH: if (branch_flag_i && req && !bus.imem_ack_i) state <= IF_DROP;
        IF_DROP:  if (ack) state <= IF_FETCH;
        default:  state <= IF_BOOT;
      endcase
      if (branch_flag_i) begin
        pc <= branch_target_i;
      end else if (accept) begin
        pc <= pc + PC_W'(1);
      end
    end
  end

  if_fifo #(
    .PC_W   (PC_W),
    .INST_W (INST_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_pc   (addr),
    .push_inst (bus.imem_data_i),
    .pop       (pop_fifo),
    .flush     (branch_flag_i),
    .head_pc   (head_pc),
    .head_inst (head_inst),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed self-checking bench for if_fetch_unit
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stallreq_cpu = 1'b0;
  logic        branch_flag = 1'b0;
  logic [15:0] branch_target = 16'h0000;
  logic        stallreq_if;
  logic [15:0] pc_test;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] acc_q[$];

`ifdef IF_BYPASS_EN
  localparam int LAT = 0;
`else
  localparam int LAT = 1;
`endif

  if_fetch_unit_if #(.PC_W(16), .INST_W(16)) bus ();

  if_fetch_unit #(.PC_W(16), .INST_W(16), .RESET_PC(16'h0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .stallreq_cpu    (stallreq_cpu),
    .branch_flag_i   (branch_flag),
    .branch_target_i (branch_target),
    .bus             (bus),
    .stallreq_if_o   (stallreq_if),
    .pc_test         (pc_test)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] inst_of(input logic [15:0] a);
    return a ^ 16'h5A00;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one cycle: inputs after the edge, memory answers if enabled, outputs settle before next edge.
  task automatic cyc(input logic rdy, input logic stl, input logic br,
                     input logic [15:0] tgt, input logic ack_en);
    @(posedge clk);
    #1;
    bus.id_ready_i = rdy;
    stallreq_cpu   = stl;
    branch_flag    = br;
    branch_target  = tgt;
    #1;
    if (ack_en && bus.imem_req_o) begin
      bus.imem_ack_i  = 1'b1;
      bus.imem_data_i = inst_of(bus.imem_addr_o);
    end else begin
      bus.imem_ack_i  = 1'b0;
      bus.imem_data_i = 16'h0000;
    end
    #1;
    if (bus.id_valid_o && bus.id_ready_i) acc_q.push_back(bus.id_pc_o);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst             = 1'b0;
    bus.imem_ack_i  = 1'b0;
    bus.imem_data_i = 16'h0000;
    bus.id_ready_i  = 1'b1;
    stallreq_cpu    = 1'b0;
    branch_flag     = 1'b0;
    #1;
    chk("rst_req",     32'(bus.imem_req_o),  32'h0);
    chk("rst_addr",    32'(bus.imem_addr_o), 32'h0);
    chk("rst_valid",   32'(bus.id_valid_o),  32'h0);
    chk("rst_id_pc",   32'(bus.id_pc_o),     32'h0);
    chk("rst_id_inst", 32'(bus.id_inst_o),   32'h0);
    chk("rst_pc_test", 32'(pc_test),         32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    acc_q.delete();
    #2;
    chk("boot_req", 32'(bus.imem_req_o), 32'h0);
  endtask

  initial begin
    bus.imem_ack_i  = 1'b0;
    bus.imem_data_i = 16'h0000;
    bus.id_ready_i  = 1'b1;

    // Zero-wait memory, decode always ready.
    do_reset();
    cyc(1, 0, 0, 16'h0, 1);
    chk("t1_c1_req",     32'(bus.imem_req_o),  32'h1);
    chk("t1_c1_addr",    32'(bus.imem_addr_o), 32'h0000);
    chk("t1_c1_valid",   32'(bus.id_valid_o),  32'(LAT == 0));
    chk("t1_c1_starve",  32'(stallreq_if),     32'h1);
    chk("t1_c1_pc_test", 32'(pc_test),         32'h0000);
    cyc(1, 0, 0, 16'h0, 1);
    chk("t1_c2_addr",    32'(bus.imem_addr_o), 32'h0001);
    chk("t1_c2_valid",   32'(bus.id_valid_o),  32'h1);
    chk("t1_c2_id_pc",   32'(bus.id_pc_o),     32'(1 - LAT));
    chk("t1_c2_id_inst", 32'(bus.id_inst_o),   32'(inst_of(16'(1 - LAT))));
    chk("t1_c2_pc_test", 32'(pc_test),         32'h0001);
    cyc(1, 0, 0, 16'h0, 1);
    chk("t1_c3_addr",    32'(bus.imem_addr_o), 32'h0002);
    chk("t1_c3_id_pc",   32'(bus.id_pc_o),     32'(2 - LAT));
    chk("t1_c3_pc_test", 32'(pc_test),         32'h0002);

    // Decode back-pressure fills the FIFO, then drains without loss.
    do_reset();
    cyc(0, 0, 0, 16'h0, 1);
    cyc(0, 0, 0, 16'h0, 1);
    chk("t2_c2_id_pc",   32'(bus.id_pc_o),     32'h0000);
    cyc(0, 0, 0, 16'h0, 1);
    chk("t2_c3_req",     32'(bus.imem_req_o),  32'h0);
    chk("t2_c3_id_inst", 32'(bus.id_inst_o),   32'h5A00);
    cyc(0, 0, 0, 16'h0, 1);
    chk("t2_c4_req",     32'(bus.imem_req_o),  32'h0);
    chk("t2_c4_id_pc",   32'(bus.id_pc_o),     32'h0000);
    cyc(1, 0, 0, 16'h0, 1);
    chk("t2_c5_req",     32'(bus.imem_req_o),  32'h1);
    chk("t2_c5_addr",    32'(bus.imem_addr_o), 32'h0002);
    chk("t2_c5_starve",  32'(stallreq_if),     32'h0);
    cyc(1, 0, 0, 16'h0, 1);
    cyc(1, 0, 0, 16'h0, 1);
    cyc(1, 0, 0, 16'h0, 1);
    chk("t2_acc_n", 32'(acc_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("t2_acc_%0d", i), 32'(acc_q[i]), 32'(i));
    // Redirect with a non-empty FIFO flushes it.
    cyc(0, 0, 1, 16'h0100, 1);
    chk("t2_br_req",   32'(bus.imem_req_o),  32'h0);
    cyc(0, 0, 0, 16'h0, 0);
    chk("t2_fl_valid", 32'(bus.id_valid_o),  32'h0);
    chk("t2_fl_addr",  32'(bus.imem_addr_o), 32'h0100);

    // Slow memory with redirect while waiting: old address held, data dropped.
    do_reset();
    cyc(1, 0, 0, 16'h0, 0);
    chk("t3_c1_req",  32'(bus.imem_req_o),  32'h1);
    cyc(1, 0, 1, 16'h0040, 0);
    chk("t3_c2_req",  32'(bus.imem_req_o),  32'h1);
    chk("t3_c2_addr", 32'(bus.imem_addr_o), 32'h0000);
    cyc(1, 0, 0, 16'h0, 0);
    chk("t3_c3_addr", 32'(bus.imem_addr_o), 32'h0000);
    chk("t3_c3_pc",   32'(pc_test),         32'h0040);
    cyc(1, 0, 0, 16'h0, 1);
    chk("t3_c4_req",   32'(bus.imem_req_o),  32'h1);
    chk("t3_c4_addr",  32'(bus.imem_addr_o), 32'h0000);
    chk("t3_c4_valid", 32'(bus.id_valid_o),  32'h0);
    cyc(1, 0, 0, 16'h0, 1);
    chk("t3_c5_addr", 32'(bus.imem_addr_o), 32'h0040);
    cyc(1, 0, 0, 16'h0, 1);
    chk("t3_acc_n", 32'(acc_q.size()), 32'(2 - LAT));
    chk("t3_first", 32'(acc_q[0]),     32'h0040);

    // Global stall with one request in flight.
    do_reset();
    cyc(1, 0, 0, 16'h0, 0);
    chk("t4_c1_req", 32'(bus.imem_req_o), 32'h1);
    cyc(1, 1, 0, 16'h0, 1);
    chk("t4_c2_req",   32'(bus.imem_req_o), 32'h1);
    chk("t4_c2_valid", 32'(bus.id_valid_o), 32'h0);
    cyc(1, 1, 0, 16'h0, 1);
    chk("t4_c3_req",    32'(bus.imem_req_o), 32'h0);
    chk("t4_c3_valid",  32'(bus.id_valid_o), 32'h0);
    chk("t4_c3_pc",     32'(pc_test),        32'h0001);
    chk("t4_c3_starve", 32'(stallreq_if),    32'h0);
    cyc(1, 1, 0, 16'h0, 1);
    cyc(1, 1, 0, 16'h0, 1);
    cyc(1, 1, 0, 16'h0, 1);
    chk("t4_c6_req",   32'(bus.imem_req_o), 32'h0);
    chk("t4_c6_valid", 32'(bus.id_valid_o), 32'h0);
    cyc(1, 0, 0, 16'h0, 1);
    chk("t4_c7_valid",   32'(bus.id_valid_o),  32'h1);
    chk("t4_c7_id_pc",   32'(bus.id_pc_o),     32'h0000);
    chk("t4_c7_id_inst", 32'(bus.id_inst_o),   32'h5A00);
    chk("t4_c7_addr",    32'(bus.imem_addr_o), 32'h0001);

    // Redirect to the top of the address space wraps to zero.
    do_reset();
    cyc(1, 0, 1, 16'hFFFF, 1);
    chk("t5_c1_req",  32'(bus.imem_req_o),  32'h0);
    cyc(1, 0, 0, 16'h0, 1);
    chk("t5_c2_req",  32'(bus.imem_req_o),  32'h1);
    chk("t5_c2_addr", 32'(bus.imem_addr_o), 32'hFFFF);
    cyc(1, 0, 0, 16'h0, 1);
    chk("t5_c3_addr", 32'(bus.imem_addr_o), 32'h0000);
    chk("t5_c3_pc",   32'(pc_test),         32'h0000);
    cyc(1, 0, 0, 16'h0, 1);
    chk("t5_acc_0", 32'(acc_q[0]), 32'hFFFF);
    chk("t5_acc_1", 32'(acc_q[1]), 32'h0000);

    // Reset asserted while a request is outstanding.
    cyc(1, 0, 0, 16'h0, 0);
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
